// File: rtl/dmem_responder.sv
// dmem_responder: stallable data-memory responder for the core's load/store port.
// Ports: clk, reset (async, active-low); request channel req_valid/req_ready with
//   req_we, req_funct3, req_addr, req_wdata; response channel rsp_valid/rsp_ready
//   with rsp_rdata, rsp_err.
// Build option: DMEM_MISALIGN_ERR_EN turns misaligned H/W accesses into errors;
//   otherwise the offending low address bits are forced to 0.
module dmem_responder #(
    parameter int DEPTH_WORDS = 1024,
    parameter int LATENCY     = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [2:0]  req_funct3,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err
);

    localparam int AW = $clog2(DEPTH_WORDS);
    localparam int CW = (LATENCY > 1) ? $clog2(LATENCY) : 1;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_WAIT = 2'd1;
    localparam logic [1:0] S_RESP = 2'd2;

    logic [1:0]      r_state;
    logic [CW-1:0]   r_cnt;
    logic            r_we;
    logic [2:0]      r_f3;
    logic [AW+1:0]   r_addr;
    logic [31:0]     r_wdata;
    logic [31:0]     r_rdata;
    logic            r_err;
    logic [31:0]     r_mem [DEPTH_WORDS];

    logic [AW-1:0]   w_widx;
    logic [31:0]     w_rword;
    logic [31:0]     w_shift;
    logic [1:0]      w_off;
    logic            w_is_h;
    logic            w_is_w;
    logic            w_illegal;
    logic            w_mis;
    logic            w_err;
    logic            w_access;
    logic            w_wr_en;
    logic [31:0]     w_load;
    logic [31:0]     w_sdata;
    logic [3:0]      w_be;
    logic            w_unused_addr;

    // Upper address bits wrap silently.
    assign w_unused_addr = ^req_addr[31:AW+2];

    assign w_widx  = r_addr[AW+1:2];
    assign w_rword = r_mem[w_widx];
    assign w_is_h  = (r_f3[1:0] == 2'b01);
    assign w_is_w  = (r_f3[1:0] == 2'b10);

    // 011, 11x are undefined; BU/HU encodings have no store form.
    assign w_illegal = (r_f3 == 3'b011)
                     || (r_f3[2:1] == 2'b11)
                     || (r_f3[2] && r_we);

`ifdef DMEM_MISALIGN_ERR_EN
    assign w_mis = (w_is_h && r_addr[0])
                 || (w_is_w && (r_addr[1:0] != 2'b00));
    assign w_off = r_addr[1:0];
`else
    assign w_mis = 1'b0;
    assign w_off = w_is_w ? 2'b00
                 : w_is_h ? {r_addr[1], 1'b0}
                 : r_addr[1:0];
`endif

    assign w_err    = w_illegal || w_mis;
    assign w_access = (r_state == S_WAIT) && (r_cnt == '0);
    assign w_wr_en  = w_access && r_we && !w_err;
    assign w_shift  = w_rword >> {w_off, 3'b000};

    always_comb begin
        w_load = 32'h0;
        if (!r_we && !w_err) begin
            case (r_f3)
                3'b000:  w_load = {{24{w_shift[7]}}, w_shift[7:0]};
                3'b001:  w_load = {{16{w_shift[15]}}, w_shift[15:0]};
                3'b010:  w_load = w_shift;
                3'b100:  w_load = {24'h0, w_shift[7:0]};
                3'b101:  w_load = {16'h0, w_shift[15:0]};
                default: w_load = 32'h0;
            endcase
        end
    end

    // Store data is replicated across lanes; byte enables pick the target.
    always_comb begin
        w_sdata = r_wdata;
        w_be    = 4'b1111;
        if (w_is_h) begin
            w_sdata = {2{r_wdata[15:0]}};
            w_be    = 4'b0011 << w_off;
        end else if (!w_is_w) begin
            w_sdata = {4{r_wdata[7:0]}};
            w_be    = 4'b0001 << w_off;
        end
    end

    always_ff @(posedge clk) begin
        if (w_wr_en) begin
            for (int i = 0; i < 4; i++) begin
                if (w_be[i]) begin
                    r_mem[w_widx][8*i +: 8] <= w_sdata[8*i +: 8];
                end
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
            r_we    <= 1'b0;
            r_f3    <= 3'b000;
            r_addr  <= '0;
            r_wdata <= 32'h0;
            r_rdata <= 32'h0;
            r_err   <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (req_valid) begin
                        r_we    <= req_we;
                        r_f3    <= req_funct3;
                        r_addr  <= req_addr[AW+1:0];
                        r_wdata <= req_wdata;
                        r_cnt   <= CW'(LATENCY - 1);
                        r_state <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (r_cnt == '0) begin
                        r_rdata <= w_load;
                        r_err   <= w_err;
                        r_state <= S_RESP;
                    end else begin
                        r_cnt <= r_cnt - 1'b1;
                    end
                end
                S_RESP: begin
                    if (rsp_ready) begin
                        r_state <= S_IDLE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign req_ready = (r_state == S_IDLE);
    assign rsp_valid = (r_state == S_RESP);
    assign rsp_rdata = r_rdata;
    assign rsp_err   = r_err;

endmodule
